// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter (mem_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_e;

    typedef logic port_id_t;

    localparam int AWIDTH_DEF      = 9;
    localparam int DWIDTH_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 16;
    localparam int STAT_W          = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to ptr.
module mem_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   ptr,
    output logic       gnt_valid,
    output port_id_t   gnt_id
);

    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = ptr;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port memory.
// Define MEM_ARB_STATS_EN to add saturating per-port ack and timeout counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH      = AWIDTH_DEF,
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [AWIDTH-1:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DWIDTH-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DWIDTH-1:0] p1_rdata,
    output logic              err,
    output logic              busy,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [AWIDTH-1:0] addr_mem,
    output logic [DWIDTH-1:0] data_in,
    input  logic              ready_mem,
    input  logic [DWIDTH-1:0] data_out
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] p0_cnt,
    output logic [STAT_W-1:0] p1_cnt,
    output logic [STAT_W-1:0] tmo_cnt
`endif
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e        state_q, state_d;
    port_id_t          ptr_q, ptr_d;
    port_id_t          id_q, id_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] p0_rdata_q, p0_rdata_d;
    logic [DWIDTH-1:0] p1_rdata_q, p1_rdata_d;
    logic              gnt_valid;
    port_id_t          gnt_id;

    mem_rr_pick u_pick (
        .req       ({p1_req, p0_req}),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        p0_ack     = 1'b0;
        p1_ack     = 1'b0;
        err        = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid && ready_mem) begin
                    id_d    = gnt_id;
                    we_d    = gnt_id ? p1_we    : p0_we;
                    addr_d  = gnt_id ? p1_addr  : p0_addr;
                    wdata_d = gnt_id ? p1_wdata : p0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wr_mem  = we_q;
                rd_mem  = !we_q;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (ready_mem) begin
                    if (!we_q) begin
                        if (id_q) p1_rdata_d = data_out;
                        else      p0_rdata_d = data_out;
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                p0_ack  = !id_q;
                p1_ack  = id_q;
                err     = err_q;
                ptr_d   = ~id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign addr_mem = addr_q;
    assign data_in  = wdata_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] p0_cnt_q, p1_cnt_q, tmo_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_cnt_q  <= '0;
            p1_cnt_q  <= '0;
            tmo_cnt_q <= '0;
        end else if (state_q == DONE) begin
            if (id_q) p1_cnt_q <= sat_inc(p1_cnt_q);
            else      p0_cnt_q <= sat_inc(p0_cnt_q);
            if (err_q) tmo_cnt_q <= sat_inc(tmo_cnt_q);
        end
    end

    assign p0_cnt  = p0_cnt_q;
    assign p1_cnt  = p1_cnt_q;
    assign tmo_cnt = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural main-memory model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       p0_req = 1'b0, p0_we = 1'b0;
    logic [8:0] p0_addr = '0;
    logic [7:0] p0_wdata = '0;
    logic       p1_req = 1'b0, p1_we = 1'b0;
    logic [8:0] p1_addr = '0;
    logic [7:0] p1_wdata = '0;
    logic       p0_ack, p1_ack, err, busy, rd_mem, wr_mem;
    logic [7:0] p0_rdata, p1_rdata, data_in;
    logic [8:0] addr_mem;
    logic       ready_mem;
    logic [7:0] data_out = '0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] p0_cnt, p1_cnt, tmo_cnt;
`endif

    mem_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_rdata  (p1_rdata),
        .err       (err),
        .busy      (busy),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .addr_mem  (addr_mem),
        .data_in   (data_in),
        .ready_mem (ready_mem),
        .data_out  (data_out)
`ifdef MEM_ARB_STATS_EN
        ,
        .p0_cnt    (p0_cnt),
        .p1_cnt    (p1_cnt),
        .tmo_cnt   (tmo_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: a strobe drops ready for one cycle, or until stall clears.
    logic [7:0] mem [512];
    bit         mem_init = 1'b0;
    logic       rdy_q;
    bit         stall = 1'b0;
    bit         hold_low = 1'b0;

    assign ready_mem = rdy_q && !hold_low;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q <= 1'b1;
            if (!mem_init) begin
                for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'h5A;
                mem_init <= 1'b1;
            end
        end else if (rd_mem || wr_mem) begin
            rdy_q <= 1'b0;
            if (wr_mem) mem[addr_mem] <= data_in;
            else        data_out <= mem[addr_mem];
        end else if (!rdy_q && !stall) begin
            rdy_q <= 1'b1;
        end
    end

    int         n_rd = 0, n_wr = 0, n_both = 0, n_ack = 0, n_err_noack = 0;
    logic [8:0] last_wa = '0;
    logic [7:0] last_wd = '0;

    always @(negedge clk) begin
        if (rd_mem) n_rd++;
        if (wr_mem) begin
            n_wr++;
            last_wa = addr_mem;
            last_wd = data_in;
        end
        if (rd_mem && wr_mem) n_both++;
        if (p0_ack || p1_ack) n_ack++;
        if (err && !(p0_ack || p1_ack)) n_err_noack++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        check("idle_seen", 32'(ok), 32'd1);
    endtask

    task automatic do_txn(input bit port, input bit we, input logic [8:0] addr,
                          input logic [7:0] wd, output int lat,
                          output logic [7:0] rd, output logic e);
        bit got = 1'b0;
        wait_idle();
        if (!port) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end
        lat = 0;
        rd  = '0;
        e   = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if ((!port && p0_ack) || (port && p1_ack)) begin
                got = 1'b1;
                lat = i;
                e   = err;
                rd  = port ? p1_rdata : p0_rdata;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({busy, p0_ack, p1_ack, err, rd_mem, wr_mem}), 32'd0);
        check({tag, "_mem"}, 32'({addr_mem, data_in}), 32'd0);
        check({tag, "_rdata"}, 32'({p0_rdata, p1_rdata}), 32'd0);
    endtask

    initial begin
        int         lat;
        logic [7:0] rd;
        logic       e;
        int         r0, w0, a0, nacks;
        int         ack_i [4];
        bit         ack_p [4];
        bit         first_p;
        bit         got;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Both ports read and hold req right after reset: p0, p1, p0, p1 every 5 cycles
        @(negedge clk);
        r0 = n_rd; w0 = n_wr;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h020;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h021;
        nacks = 0;
        for (int i = 1; i <= 40 && nacks < 4; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                ack_i[nacks] = i;
                ack_p[nacks] = p1_ack;
                nacks++;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("rr_ack_count", 32'(nacks), 32'd4);
        check("rr_order", 32'({ack_p[0], ack_p[1], ack_p[2], ack_p[3]}), 32'b0101);
        check("rr_first_latency", 32'(ack_i[0]), 32'd4);
        for (int k = 1; k < 4; k++) check("rr_spacing", 32'(ack_i[k] - ack_i[k-1]), 32'd5);
        check("rr_rd_strobes", 32'(n_rd - r0), 32'd4);
        check("rr_wr_strobes", 32'(n_wr - w0), 32'd0);
        check("rr_p0_rdata", 32'(p0_rdata), 32'h7A);
        check("rr_p1_rdata", 32'(p1_rdata), 32'h7B);

        // p0 write 0x012 <- 0xA5 then read it back
        r0 = n_rd; w0 = n_wr;
        do_txn(1'b0, 1'b1, 9'h012, 8'hA5, lat, rd, e);
        check("wr_latency", 32'(lat), 32'd4);
        check("wr_strobes", 32'(n_wr - w0), 32'd1);
        check("wr_no_rd", 32'(n_rd - r0), 32'd0);
        check("wr_addr", 32'(last_wa), 32'h012);
        check("wr_data", 32'(last_wd), 32'hA5);
        check("wr_err", 32'(e), 32'd0);
        do_txn(1'b0, 1'b0, 9'h012, 8'h00, lat, rd, e);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_data", 32'(rd), 32'hA5);
        check("rd_err", 32'(e), 32'd0);

        // p1 writes 0x3C to 0x1FF, p0 reads it; p1_rdata untouched by the write
        do_txn(1'b1, 1'b1, 9'h1FF, 8'h3C, lat, rd, e);
        check("p1_wr_err", 32'(e), 32'd0);
        do_txn(1'b0, 1'b0, 9'h1FF, 8'h00, lat, rd, e);
        check("x_port_rdata", 32'(rd), 32'h3C);
        check("p1_rdata_kept", 32'(p1_rdata), 32'h7B);

        // Memory never returns ready: timeout after 16 WAIT cycles
        stall = 1'b1;
        r0 = n_rd;
        do_txn(1'b0, 1'b0, 9'h005, 8'h00, lat, rd, e);
        stall = 1'b0;
        check("tmo_latency", 32'(lat), 32'd18);
        check("tmo_err", 32'(e), 32'd1);
        check("tmo_rdata_kept", 32'(rd), 32'h3C);
        check("tmo_one_strobe", 32'(n_rd - r0), 32'd1);
        do_txn(1'b0, 1'b0, 9'h005, 8'h00, lat, rd, e);
        check("post_tmo_latency", 32'(lat), 32'd4);
        check("post_tmo_data", 32'(rd), 32'h5F);
        check("post_tmo_err", 32'(e), 32'd0);

        // Reset dropped mid-WAIT: outputs clear at once, no ack
        wait_idle();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h030;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        p0_req = 1'b0;
        a0 = n_ack;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_ack_after_reset", 32'(n_ack - a0), 32'd0);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h031;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h032;
        got = 1'b0;
        first_p = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                got = 1'b1;
                first_p = p1_ack;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("post_reset_ack_seen", 32'(got), 32'd1);
        check("post_reset_first_p0", 32'(first_p), 32'd0);
        check("post_reset_rdata", 32'(p0_rdata), 32'h6B);

        // ready_mem low in IDLE holds off the grant
        hold_low = 1'b1;
        wait_idle();
        w0 = n_wr;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h040; p0_wdata = 8'h11;
        repeat (5) @(negedge clk);
        check("hold_no_strobe", 32'(n_wr - w0), 32'd0);
        check("hold_idle", 32'(busy), 32'd0);
        hold_low = 1'b0;
        @(negedge clk);
        check("hold_strobe_next", 32'({wr_mem, rd_mem}), 32'b10);
        check("hold_strobe_addr", 32'(addr_mem), 32'h040);
        got = 1'b0;
        e = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (p0_ack) begin
                got = 1'b1;
                e = err;
            end
        end
        p0_req = 1'b0;
        check("hold_ack_seen", 32'(got), 32'd1);
        check("hold_err", 32'(e), 32'd0);

        // Global strobe and err invariants
        repeat (2) @(negedge clk);
        check("never_both_strobes", 32'(n_both), 32'd0);
        check("err_only_with_ack", 32'(n_err_noack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
